ref_shift_scan_ctrl: RTL and testbench
======================================

Name: ref_shift_scan_ctrl

Overview:
- Sequencer for the reference-memory shift array in the motion-estimation datapath.
- For each vertical search position it requests one reference band load, then steps the array's 5-bit shift amount across the band.
- Emits one shifted candidate per accepted cycle to the PE array, with ready/valid backpressure.
- Started by the ME top controller via a start/busy/done handshake.

Parameters:
- SHIFT_W, 5, width of shift_value; max shift = 2**SHIFT_W-1 (31).
- ROW_W, 7, width of the reference row address and row counters.
- CNT_W, 7, width of the search_rows config field.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE next cycle, no done.
- cfg_row_base  in  ROW_W  first reference row address; latched at start.
- cfg_search_rows  in  CNT_W  number of vertical positions; 0 treated as 1; latched at start.
- cfg_shift_step  in  SHIFT_W  shift increment; 0 treated as 1; latched at start.
- out_ready  in  1  downstream accepts the current shift cycle.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on scan completion.
- ref_load  out  1  one-cycle band-load strobe to the reference memory.
- ref_row_addr  out  ROW_W  cfg_row_base + row_idx; valid while ref_load is high.
- shift_value  out  SHIFT_W  shift amount to the shift array.
- shift_valid  out  1  shift_value is valid for the PE array.
- last_shift  out  1  high with shift_valid on the final shift of the final row.
- row_idx  out  ROW_W  current vertical position index.

Behaviour:
- Reset: state IDLE; all outputs 0; latched config registers 0.
- IDLE
  - start=1 latches the config and goes to LOAD; row_idx=0.
  - start in any other state is ignored.
- LOAD (exactly 1 cycle)
  - ref_load=1, ref_row_addr=cfg_row_base+row_idx (wraps mod 2**ROW_W).
  - shift_value=0; next state SHIFT.
- SHIFT
  - shift_valid=1.
  - Cycle accepted when shift_valid && out_ready.
  - No ready: shift_value and shift_valid hold; no state change.
  - On accept with next = shift_value + step:
    - next <= 31: shift_value <= next.
    - next > 31 (computed at SHIFT_W+1 bits, no wrap): row ends.
  - Row end:
    - row_idx < rows-1: row_idx++, go to LOAD.
    - Otherwise: go to DONE.
- Shifts per row: N = floor(31/step)+1 (values 0, step, 2*step, ...). Non-power-of-two steps are allowed.
- DONE (1 cycle): done=1, busy=1; next state IDLE, busy=0.
- Latency with no stalls:
  - start at cycle 0; first ref_load at cycle 1; first shift_valid at cycle 2.
  - done asserted at cycle rows*(1+N)+1.
- abort
  - Highest priority in every state except IDLE.
  - Next cycle: IDLE, all outputs 0, done not pulsed.
  - abort together with start in IDLE: start wins; abort is ignored in IDLE.
- last_shift = shift_valid && (row_idx==rows-1) && (shift_value+step > 31).
- Asynchronous rst mid-scan: immediate IDLE, all outputs 0.
- ref_row_addr reads 0 when ref_load=0.

Decomposition:
- Shared package me_pkg:
  - SHIFT_W, ROW_W, CNT_W.
  - State enum {IDLE, LOAD, SHIFT, DONE}.
  - MAX_SHIFT constant = 31.
- One natural sub-module, ref_shift_step_gen: the shift counter with step add, overflow detect and hold-on-stall. The FSM stays in the top.

Test Plan:
- Base scan: base=10, rows=2, step=8, ready=1.
  - Shifts 0,8,16,24 per row; ref_row_addr 10 then 11.
  - done at cycle 11; last_shift with the second row's 24.
- Step=0 and rows=0: behaves as step=1, rows=1.
  - Shifts 0..31 (32 cycles); done at cycle 34.
- Backpressure: step=16, out_ready low for 3 cycles while shift_value=16.
  - shift_value holds at 16 with shift_valid=1; done delayed exactly 3 cycles.
- Non-power-of-two step=12: shifts 0,12,24, then the next row's LOAD; no value exceeds 31.
- Abort during SHIFT, second row: next cycle busy=0, no done.
  - A new start two cycles later rescans from row 0 with the new config.
- Wrap and reset:
  - base=127, rows=2: ref_row_addr 127 then 0.
  - rst asserted mid-LOAD clears ref_load and busy immediately.
  - start while busy produces no restart.

Source files
------------

// File: rtl/me_pkg.sv
// Shared widths, limits and state encoding for the reference shift-scan sequencer.
package me_pkg;
  localparam int SHIFT_W = 5;
  localparam int ROW_W   = 7;
  localparam int CNT_W   = 7;

  localparam logic [SHIFT_W-1:0] MAX_SHIFT = '1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_e;
endpackage

// File: rtl/ref_shift_step_gen.sv
// Shift-amount counter: advances by step on each accepted cycle, flags when the
// next value would pass MAX_SHIFT, and holds while the consumer stalls.
module ref_shift_step_gen
  import me_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               adv_i,
  input  logic [SHIFT_W-1:0] step_i,
  output logic [SHIFT_W-1:0] value_o,
  output logic               ovf_o
);
  logic [SHIFT_W-1:0] value_q, value_d;
  logic [SHIFT_W:0]   sum;

  // One extra bit so an overshoot is seen instead of wrapping back to a small shift.
  assign sum   = {1'b0, value_q} + {1'b0, step_i};
  assign ovf_o = sum > {1'b0, MAX_SHIFT};

  always_comb begin
    value_d = value_q;
    if (clear_i)             value_d = '0;
    else if (adv_i && !ovf_o) value_d = sum[SHIFT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value_o = value_q;
endmodule

// File: rtl/ref_shift_scan_ctrl.sv
// Sequencer for the reference shift array: one band load per vertical position,
// then a stepped sweep of the shift amount under ready/valid backpressure.
module ref_shift_scan_ctrl
  import me_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [ROW_W-1:0]   cfg_row_base,
  input  logic [CNT_W-1:0]   cfg_search_rows,
  input  logic [SHIFT_W-1:0] cfg_shift_step,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               ref_load,
  output logic [ROW_W-1:0]   ref_row_addr,
  output logic [SHIFT_W-1:0] shift_value,
  output logic               shift_valid,
  output logic               last_shift,
  output logic [ROW_W-1:0]   row_idx
);
  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ROW_W-1:0]   base_q;
  logic [CNT_W-1:0]   rows_q;
  logic [SHIFT_W-1:0] step_q;

  logic               accept, ovf, last_row;
  logic [SHIFT_W-1:0] cnt_value;

  assign accept   = (state_q == SHIFT) && out_ready;
  assign last_row = (row_q == ROW_W'(rows_q - CNT_W'(1)));

  ref_shift_step_gen u_step (
    .clk     (clk),
    .rst     (rst),
    .clear_i (state_q != SHIFT),
    .adv_i   (accept),
    .step_i  (step_q),
    .value_o (cnt_value),
    .ovf_o   (ovf)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
      row_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = LOAD;
          row_d   = '0;
        end
        LOAD: state_d = SHIFT;
        SHIFT: if (accept && ovf) begin
          if (last_row) state_d = DONE;
          else begin
            row_d   = row_q + ROW_W'(1);
            state_d = LOAD;
          end
        end
        DONE: begin
          state_d = IDLE;
          row_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // Zero-valued fields are stored as 1 so the datapath never sees a degenerate scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      rows_q <= '0;
      step_q <= '0;
    end else if (state_q == IDLE && start) begin
      base_q <= cfg_row_base;
      rows_q <= (cfg_search_rows == '0) ? CNT_W'(1) : cfg_search_rows;
      step_q <= (cfg_shift_step == '0) ? SHIFT_W'(1) : cfg_shift_step;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign ref_load     = (state_q == LOAD);
  assign ref_row_addr = ref_load ? (base_q + row_q) : '0;
  assign shift_valid  = (state_q == SHIFT);
  assign shift_value  = shift_valid ? cnt_value : '0;
  assign last_shift   = shift_valid && last_row && ovf;
  assign row_idx      = row_q;
endmodule

// File: tb/tb_ref_shift_scan_ctrl.sv
// Bench for ref_shift_scan_ctrl: a per-scan schedule queue model checked every
// cycle, plus directed scans with hand-computed latencies and shift sequences.
module tb_ref_shift_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic [6:0] cfg_row_base = '0;
  logic [6:0] cfg_search_rows = '0;
  logic [4:0] cfg_shift_step = '0;
  logic       busy, done, ref_load, shift_valid, last_shift;
  logic [6:0] ref_row_addr, row_idx;
  logic [4:0] shift_value;

  int checks = 0;
  int errors = 0;

  ref_shift_scan_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_row_base(cfg_row_base), .cfg_search_rows(cfg_search_rows),
    .cfg_shift_step(cfg_shift_step), .out_ready(out_ready),
    .busy(busy), .done(done), .ref_load(ref_load), .ref_row_addr(ref_row_addr),
    .shift_value(shift_value), .shift_valid(shift_valid),
    .last_shift(last_shift), .row_idx(row_idx)
  );

  always #5 clk = ~clk;

  // Model: a started scan is the full list of cycles it will present;
  // LOAD/DONE entries last one cycle, SHIFT entries last until accepted.
  typedef struct {
    int kind;  // 0 load, 1 shift, 2 done
    int row;
    int addr;
    int val;
    bit last;
  } item_t;
  item_t sched[$];

  function automatic void build(int base, int rows, int step);
    item_t it;
    int re = (rows == 0) ? 1 : rows;
    int se = (step == 0) ? 1 : step;
    sched.delete();
    for (int r = 0; r < re; r++) begin
      it = '{kind: 0, row: r, addr: (base + r) % 128, val: 0, last: 1'b0};
      sched.push_back(it);
      for (int v = 0; v <= 31; v += se) begin
        it = '{kind: 1, row: r, addr: 0, val: v, last: (r == re - 1) && (v + se > 31)};
        sched.push_back(it);
      end
    end
    it = '{kind: 2, row: re - 1, addr: 0, val: 0, last: 1'b0};
    sched.push_back(it);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) sched.delete();
    else if (sched.size() == 0) begin
      if (start) build(cfg_row_base, cfg_search_rows, cfg_shift_step);
    end else if (abort) sched.delete();
    else if (sched[0].kind != 1 || out_ready) void'(sched.pop_front());
  end

  function automatic logic [23:0] expected_vec();
    item_t it;
    if (sched.size() == 0) return '0;
    it = sched[0];
    return {1'b1, 1'(it.kind == 2), 1'(it.kind == 0), (it.kind == 0) ? 7'(it.addr) : 7'd0,
            1'(it.kind == 1), (it.kind == 1) ? 5'(it.val) : 5'd0, it.last, 7'(it.row)};
  endfunction

  always @(posedge clk) begin
    logic [23:0] act, exp;
    #1;
    act = {busy, done, ref_load, ref_row_addr, shift_valid, shift_value, last_shift, row_idx};
    exp = expected_vec();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model_cycle t=%0t got=%h expected=%h", $time, act, exp);
    end
  end

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  int vals[$];
  int addrs[$];
  int lastv, lastrow;

  // Runs one scan from the cycle start is high (cycle 0) and returns the done cycle.
  task automatic run(input int base, input int rows, input int step, input int stall_val,
                     input int stall_n, input int spur_at, output int cyc);
    int stalls = 0;
    bit got = 0;
    vals.delete(); addrs.delete(); lastv = -1; lastrow = -1;
    @(negedge clk);
    cfg_row_base = 7'(base); cfg_search_rows = 7'(rows); cfg_shift_step = 5'(step);
    start = 1'b1; out_ready = 1'b1;
    cyc = 0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1; cyc++;
      if (done) begin got = 1; break; end
      @(negedge clk);
      start = (cyc == spur_at);
      if (cyc == spur_at) begin
        cfg_row_base = 7'd55; cfg_search_rows = 7'd9; cfg_shift_step = 5'd3;
      end
      if (ref_load) addrs.push_back(int'(ref_row_addr));
      if (shift_valid && int'(shift_value) == stall_val && stalls < stall_n) begin
        out_ready = 1'b0; stalls++;
      end else out_ready = 1'b1;
      if (shift_valid && out_ready) begin
        vals.push_back(int'(shift_value));
        if (last_shift) begin lastv = int'(shift_value); lastrow = int'(row_idx); end
      end
    end
    if (!got) check_eq("scan_timeout", 0, 1);
    @(negedge clk); start = 1'b0; out_ready = 1'b1;
  endtask

  task automatic check_list(input string name, input int exp[], input int got_q[$]);
    check_eq({name, "_len"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      check_eq(name, got_q[i], exp[i]);
  endtask

  initial begin
    int cyc;
    int e[];
    bit found;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outputs",
             int'({busy, done, ref_load, ref_row_addr, shift_valid, shift_value, last_shift, row_idx}), 0);
    @(negedge clk); rst = 1'b0;

    // base scan
    run(10, 2, 8, -1, 0, -1, cyc);
    check_eq("base_done_cycle", cyc, 11);
    e = '{0, 8, 16, 24, 0, 8, 16, 24}; check_list("base_shifts", e, vals);
    e = '{10, 11}; check_list("base_addrs", e, addrs);
    check_eq("base_last_val", lastv, 24);
    check_eq("base_last_row", lastrow, 1);

    // zero step / zero rows
    run(5, 0, 0, -1, 0, -1, cyc);
    check_eq("zero_done_cycle", cyc, 34);
    check_eq("zero_nshifts", vals.size(), 32);
    check_eq("zero_last_val", lastv, 31);

    // backpressure
    run(0, 1, 16, 16, 3, -1, cyc);
    check_eq("bp_done_cycle", cyc, 7);
    e = '{0, 16}; check_list("bp_shifts", e, vals);

    // non-power-of-two step
    run(40, 2, 12, -1, 0, -1, cyc);
    check_eq("step12_done_cycle", cyc, 9);
    e = '{0, 12, 24, 0, 12, 24}; check_list("step12_shifts", e, vals);

    // wrap with a start pulse while busy
    run(127, 2, 16, -1, 0, 4, cyc);
    check_eq("wrap_done_cycle", cyc, 7);
    e = '{127, 0}; check_list("wrap_addrs", e, addrs);
    repeat (2) @(posedge clk);
    #1; check_eq("wrap_idle_after", int'(busy), 0);

    // abort in second row, restart two cycles later
    @(negedge clk);
    cfg_row_base = 7'd3; cfg_search_rows = 7'd2; cfg_shift_step = 5'd8; start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (shift_valid && row_idx == 7'd1) begin found = 1; break; end
    end
    check_eq("abort_reach_row1", int'(found), 1);
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_done", int'(done), 0);
    @(negedge clk); abort = 1'b0;
    @(negedge clk);
    cfg_row_base = 7'd20; cfg_search_rows = 7'd1; cfg_shift_step = 5'd16; start = 1'b1;
    @(posedge clk); #1;
    check_eq("restart_load", int'(ref_load), 1);
    check_eq("restart_addr", int'(ref_row_addr), 20);
    check_eq("restart_row", int'(row_idx), 0);
    @(negedge clk); start = 1'b0;
    repeat (6) @(posedge clk);

    // async reset during LOAD
    @(negedge clk);
    cfg_row_base = 7'd1; cfg_search_rows = 7'd3; cfg_shift_step = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_pre_load", int'(ref_load), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_load", int'(ref_load), 0);
    check_eq("rst_async_busy", int'(busy), 0);
    @(negedge clk); rst = 1'b0; start = 1'b0;

    // randomized traffic, checked every cycle by the model
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      out_ready       = ($urandom_range(0, 3) != 0);
      start           = ($urandom_range(0, 7) == 0);
      abort           = ($urandom_range(0, 79) == 0);
      cfg_row_base    = 7'($urandom);
      cfg_search_rows = 7'($urandom_range(0, 3));
      cfg_shift_step  = 5'($urandom);
    end
    @(negedge clk); start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (300) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
